// File: rtl/if_fetch_unit_if.sv
// Instruction ROM request/response bus.
// master: rom_ce/rom_addr out, rom_ack/rom_data in.
interface if_fetch_unit_if #(
  parameter int DW = 32
);
  logic          rom_ce;
  logic [DW-1:0] rom_addr;
  logic          rom_ack;
  logic [DW-1:0] rom_data;

  modport master (
    output rom_ce,
    output rom_addr,
    input  rom_ack,
    input  rom_data
  );

  modport slave (
    input  rom_ce,
    input  rom_addr,
    output rom_ack,
    output rom_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: owns fetch PC, drives variable-latency ROM,
// presents pc/rom_ins to IF/ID, handles branch + flush.
module if_fetch_unit #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] RESET_PC = '0,
  parameter int            PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    stop,
  input  logic          branch_flag,
  input  logic [DW-1:0] branch_target,
  input  logic          flush,
  input  logic [DW-1:0] new_pc,
  if_fetch_unit_if.master rom,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] rom_ins,
  output logic          stallreq_if
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HAVE,
    DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] fpc_q, fpc_d;
  logic          ce_q, ce_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ins_q, ins_d;
  logic          rp_q, rp_d;
  logic [DW-1:0] rt_q, rt_d;

  logic          accept;
  logic [DW-1:0] nxt;

  logic unused_stop;
  assign unused_stop = ^{stop[5:3], stop[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fpc_q   <= RESET_PC;
      ce_q    <= 1'b0;
      addr_q  <= '0;
      pc_q    <= '0;
      ins_q   <= '0;
      rp_q    <= 1'b0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      ce_q    <= ce_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      rp_q    <= rp_d;
      rt_q    <= rt_d;
    end
  end

  assign accept = (state_q == HAVE) && !stop[1];

  always_comb begin
    if (branch_flag)
      nxt = branch_target;
    else if (rp_q)
      nxt = rt_q;
    else
      nxt = pc_q + DW'(PC_STEP);
  end

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    ce_d    = ce_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    rp_d    = rp_q;
    rt_d    = rt_q;

    // A branch seen while IF cannot consume it directly is
    // remembered until the next accept.
    if (branch_flag && !stop[2] && !accept) begin
      rp_d = 1'b1;
      rt_d = branch_target;
    end
    if (flush)
      rp_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        ce_d    = 1'b1;
        state_d = REQ;
        addr_d  = flush ? new_pc : fpc_q;
        fpc_d   = flush ? new_pc : fpc_q;
      end
      REQ: begin
        if (flush) begin
          fpc_d = new_pc;
          if (rom.rom_ack) begin
            addr_d  = new_pc;
            state_d = REQ;
          end else begin
            // issued request stays on the bus until acked
            state_d = DRAIN;
          end
        end else if (rom.rom_ack) begin
          pc_d    = addr_q;
          ins_d   = rom.rom_data;
          ce_d    = 1'b0;
          state_d = HAVE;
        end
      end
      HAVE: begin
        if (flush) begin
          fpc_d   = new_pc;
          addr_d  = new_pc;
          ce_d    = 1'b1;
          state_d = REQ;
        end else if (accept) begin
          fpc_d   = nxt;
          addr_d  = nxt;
          ce_d    = 1'b1;
          rp_d    = 1'b0;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (flush)
          fpc_d = new_pc;
        if (rom.rom_ack) begin
          addr_d  = fpc_d;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rom.rom_ce   = ce_q;
  assign rom.rom_addr = addr_q;
  assign pc           = pc_q;
  assign rom_ins      = ins_q;
  assign stallreq_if  = (state_q != HAVE);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: wait-state ROM model,
// request/instruction scoreboards, directed scenarios.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stop = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = '0;
  logic [31:0] pc;
  logic [31:0] rom_ins;
  logic        stallreq_if;

  if_fetch_unit_if #(.DW(32)) rom_bus ();

  if_fetch_unit #(
    .DW(32),
    .RESET_PC(32'h0),
    .PC_STEP(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stop         (stop),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .flush        (flush),
    .new_pc       (new_pc),
    .rom          (rom_bus),
    .pc           (pc),
    .rom_ins      (rom_ins),
    .stallreq_if  (stallreq_if)
  );

  always #5 clk = ~clk;

  // ROM: data = addr + 0x100, wait_n waits at wait_addr
  logic [31:0] wait_addr = 32'h8;
  int          wait_n = 3;
  int          cnt = 0;
  int          need;

  always_comb begin
    need = (rom_bus.rom_addr == wait_addr) ? wait_n : 0;
  end

  assign rom_bus.rom_ack  = rom_bus.rom_ce && (cnt == need);
  assign rom_bus.rom_data = rom_bus.rom_addr + 32'h100;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 0;
    else if (!rom_bus.rom_ce || rom_bus.rom_ack)
      cnt <= 0;
    else
      cnt <= cnt + 1;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] exp_ack[$];
  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];
  logic        prev_stall = 1'b1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_bus.rom_ce && rom_bus.rom_ack) begin
        if (exp_ack.size() == 0)
          chk("extra_ack", rom_bus.rom_addr, 32'hDEAD_BEEF);
        else
          chk("ack_addr", rom_bus.rom_addr, exp_ack.pop_front());
      end
      if (!stallreq_if && prev_stall) begin
        if (exp_pc.size() == 0) begin
          chk("extra_pc", pc, 32'hDEAD_BEEF);
        end else begin
          chk("out_pc", pc, exp_pc.pop_front());
          chk("out_ins", rom_ins, exp_ins.pop_front());
        end
      end
    end
    prev_stall = stallreq_if;
  end

  task automatic wait_req(input logic [31:0] a);
    int n = 0;
    while (!(rom_bus.rom_ce && rom_bus.rom_addr == a)
           && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("req_%h", a),
        32'(rom_bus.rom_ce && rom_bus.rom_addr == a), 32'd1);
  endtask

  task automatic wait_have(input logic [31:0] a);
    int n = 0;
    while (!(!stallreq_if && pc == a) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("have_%h", a),
        32'(!stallreq_if && pc == a), 32'd1);
  endtask

  task automatic push_i(input logic [31:0] a);
    exp_pc.push_back(a);
    exp_ins.push_back(a + 32'h100);
  endtask

  initial begin
    exp_ack = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10,
                32'h14, 32'h200, 32'h20, 32'h180,
                32'h20, 32'h180, 32'hFFFF_FFFC,
                32'h0, 32'h0};
    push_i(32'h0);   push_i(32'h4);
    push_i(32'h8);   push_i(32'hC);
    push_i(32'h10);  push_i(32'h14);
    push_i(32'h200); push_i(32'h180);
    push_i(32'h180); push_i(32'hFFFF_FFFC);
    push_i(32'h0);   push_i(32'h0);

    repeat (2) @(negedge clk);
    chk("rst_ce", 32'(rom_bus.rom_ce), 32'd0);
    chk("rst_addr", rom_bus.rom_addr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ins", rom_ins, 32'd0);
    chk("rst_stall", 32'(stallreq_if), 32'd1);
    rst_n = 1'b1;

    // 3 wait cycles at 0x8
    wait_req(32'h8);
    for (int i = 0; i < 4; i++) begin
      chk("w_ce", 32'(rom_bus.rom_ce), 32'd1);
      chk("w_addr", rom_bus.rom_addr, 32'h8);
      chk("w_stall", 32'(stallreq_if), 32'd1);
      chk("w_ack", 32'(rom_bus.rom_ack), 32'(i == 3));
      @(negedge clk);
    end

    // hold HAVE at 0x10
    wait_req(32'h10);
    stop = 6'b000010;
    wait_have(32'h10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("h_pc", pc, 32'h10);
      chk("h_ins", rom_ins, 32'h110);
      chk("h_ce", 32'(rom_bus.rom_ce), 32'd0);
      chk("h_stall", 32'(stallreq_if), 32'd0);
    end
    stop = '0;
    @(negedge clk);
    chk("rel_addr", rom_bus.rom_addr, 32'h14);
    chk("rel_ce", 32'(rom_bus.rom_ce), 32'd1);

    // branch captured during REQ of delay slot
    branch_flag = 1'b1;
    branch_target = 32'h200;
    @(negedge clk);
    branch_flag = 1'b0;
    wait_have(32'h200);

    // branch to 0x20, then flush while it waits
    wait_addr = 32'h20;
    wait_n = 3;
    branch_flag = 1'b1;
    branch_target = 32'h20;
    @(negedge clk);
    branch_flag = 1'b0;
    flush = 1'b1;
    new_pc = 32'h180;
    @(negedge clk);
    flush = 1'b0;
    chk("dr_ce", 32'(rom_bus.rom_ce), 32'd1);
    chk("dr_addr", rom_bus.rom_addr, 32'h20);
    chk("dr_stall", 32'(stallreq_if), 32'd1);
    wait_have(32'h180);

    // flush coinciding with ack: no DRAIN
    wait_n = 0;
    branch_flag = 1'b1;
    branch_target = 32'h20;
    @(negedge clk);
    branch_flag = 1'b0;
    chk("sc_ack", 32'(rom_bus.rom_ack), 32'd1);
    flush = 1'b1;
    new_pc = 32'h180;
    @(negedge clk);
    flush = 1'b0;
    chk("sc_addr", rom_bus.rom_addr, 32'h180);
    chk("sc_ce", 32'(rom_bus.rom_ce), 32'd1);
    wait_have(32'h180);

    // wrap past top of address space
    flush = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    flush = 1'b0;
    wait_have(32'hFFFF_FFFC);
    wait_addr = 32'h4;
    wait_n = 20;
    @(negedge clk);
    chk("wrap_addr", rom_bus.rom_addr, 32'h0);
    chk("wrap_ce", 32'(rom_bus.rom_ce), 32'd1);

    // async reset in the middle of a request
    wait_req(32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ce", 32'(rom_bus.rom_ce), 32'd0);
    chk("ar_addr", rom_bus.rom_addr, 32'd0);
    chk("ar_pc", pc, 32'd0);
    chk("ar_ins", rom_ins, 32'd0);
    chk("ar_stall", 32'(stallreq_if), 32'd1);
    stop = 6'b000010;
    wait_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_have(32'h0);

    repeat (5) @(negedge clk);
    chk("ack_left", 32'(exp_ack.size()), 32'd0);
    chk("ins_left", 32'(exp_pc.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage front end: owns the architectural fetch PC and issues requests to a variable-latency instruction ROM.
- Presents each returned instruction, with its address, to the IF/ID pipeline register on pc/rom_ins.
- Raises stallreq_if while a fetch is outstanding, so the stall controller inserts IF/ID bubbles.
- Applies branch redirects, including those taken while a fetch is outstanding, and exception flushes.

Parameters:
DW, 32, data/address width (matches `DataWidth)
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential address increment

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
stop  in  6  pipeline stall vector; bit1 = IF/ID hold, bit2 = ID/EX hold; `Stop=1, `NoStop=0
branch_flag  in  1  ID-stage branch taken (delay slot is the next sequential instruction)
branch_target  in  DW  taken-branch address
flush  in  1  exception flush, priority over everything except reset
new_pc  in  DW  flush restart address
rom_ce  out  1  ROM request
rom_addr  out  DW  ROM word address, registered
rom_ack  in  1  ROM data valid this cycle (may coincide with rom_ce first cycle)
rom_data  in  DW  ROM read data
pc  out  DW  address of instruction on rom_ins
rom_ins  out  DW  fetched instruction
stallreq_if  out  1  fetch not ready; combinational from state

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, fetch_pc=RESET_PC.
  - rom_ce=0, rom_addr=0, pc=0, rom_ins=0.
  - redir_pend=0, redir_tgt=0. stallreq_if=1 while in IDLE/REQ/DRAIN.
- States: IDLE, REQ, HAVE, DRAIN.
- IDLE: next edge -> REQ with rom_ce=1, rom_addr=fetch_pc.
- REQ: rom_ce=1, rom_addr held stable until rom_ack. stallreq_if=1.
  - rom_ack=1 -> pc<=rom_addr, rom_ins<=rom_data, rom_ce<=0, state->HAVE.
- HAVE: stallreq_if=0; pc/rom_ins held constant.
  - stop[1]==`Stop: stay HAVE.
  - stop[1]==`NoStop: instruction consumed this edge. nxt = branch_target if branch_flag, else redir_tgt if redir_pend, else pc+PC_STEP. Set fetch_pc<=nxt, rom_addr<=nxt, rom_ce<=1, clear redir_pend, state->REQ.
- Branch capture: in any state other than HAVE-with-accept, a cycle with branch_flag=1 and stop[2]==`NoStop sets redir_pend=1 and redir_tgt=branch_target. The later value wins.
- Arithmetic: PC increment is modulo 2^DW; 32'hFFFF_FFFC + 4 wraps to 0. No alignment check.
- Flush (flush=1, any state):
  - Clears redir_pend.
  - From HAVE/IDLE: fetch_pc=rom_addr=new_pc, rom_ce=1 -> REQ.
  - From REQ with rom_ack=0: -> DRAIN, fetch_pc<=new_pc. rom_ce/rom_addr are held, because an issued request is never withdrawn.
  - From REQ with rom_ack=1 the same cycle: data discarded, -> REQ at new_pc.
- DRAIN: stallreq_if=1, rom_ce=1 on the old address.
  - On rom_ack: discard data, rom_addr<=fetch_pc, -> REQ.
  - A further flush in DRAIN only updates fetch_pc.
- pc/rom_ins update only on a REQ acknowledge. Flush does not clear them; downstream relies on stallreq_if.
- Throughput: one instruction per two cycles with a zero-wait ROM; N wait cycles add N.
- No outputs are combinational from rom_data.

Test Plan:
- Reset release, zero-wait ROM returning addr+0x100, stop=0:
  - rom_addr sequence 0,4,8.
  - pc/rom_ins = 0/0x100 then 4/0x104, each valid in HAVE.
  - stallreq_if alternates 1,0.
- ROM with 3 wait cycles at addr 8: rom_ce=1 and rom_addr=8 held for 4 cycles, stallreq_if=1 throughout; pc=8 is presented after rom_ack.
- HAVE with pc=0x10, stop[1]=1 for 5 cycles: pc/rom_ins constant, rom_ce=0; release -> rom_addr=0x14.
- branch_flag=1, target 0x200, pulsed during REQ for addr 0x14 (delay slot) with stop[2]=0: 0x14 still delivered, next rom_addr=0x200.
- flush with new_pc=0x180 while REQ at 0x20 is waiting:
  - 0x20 data discarded; pc never shows 0x20.
  - Next rom_addr=0x180 after ack.
  - Repeat with rom_ack in the same cycle -> next request 0x180 with no DRAIN.
- fetch_pc=32'hFFFF_FFFC accepted -> rom_addr=0. Async reset asserted mid-REQ -> all outputs 0 immediately, restart at RESET_PC.
